// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI line fetch controller.
package hdmi_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

    localparam int RD_LEN_W = 16;
endpackage

// File: rtl/hdmi_edge_det.sv
// Registers a timing signal once and reports its rising and falling edges.
module hdmi_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);
    logic sig_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= RST_VAL;
        else     sig_q <= sig_i;
    end

    assign rise_o = ~sig_q & sig_i;
    assign fall_o = sig_q & ~sig_i;
endmodule

// File: rtl/hdmi_line_fetch_ctrl.sv
// Fetches active video lines into a two-line ping-pong buffer, keeping at most
// two lines ahead of the display and flagging lines whose data arrived late.
module hdmi_line_fetch_ctrl
    import hdmi_pkg::*;
#(
    parameter int                    V_ACTIVE_LINE = 720,
    parameter int                    LINE_WORDS    = 160,
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter logic [ADDR_WIDTH-1:0] LINE_STRIDE   = ADDR_WIDTH'(640)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  de,
    input  logic                  vsync,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [RD_LEN_W-1:0]   rd_len,
    input  logic                  rd_ack,
    input  logic                  rd_done,
    output logic                  wr_buf,
    output logic                  rd_buf,
    output logic                  underflow
);
    localparam int                LINE_W    = $clog2(V_ACTIVE_LINE + 1);
    localparam logic [LINE_W-1:0] V_LINES   = LINE_W'(V_ACTIVE_LINE);
    localparam logic [1:0]        PEND_INIT = (V_ACTIVE_LINE >= 2) ? 2'd2 : 2'(V_ACTIVE_LINE);

    fetch_state_e          state_q;
    logic                  rd_req_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [1:0]            pending_q, pending_d;
    logic [1:0]            buf_valid_q, buf_valid_d;
    logic [LINE_W-1:0]     disp_line_q, fetch_line_q;
    logic                  discard_q;
    logic                  underflow_q;

    logic de_rise, de_fall, frame_start, vsync_fall_unused;
    logic done_ok, disp_adv, pend_inc;
    logic [2:0] pend_sum;

    hdmi_edge_det #(.RST_VAL(1'b0)) u_de_edge (
        .clk(clk), .rst(rst), .sig_i(de), .rise_o(de_rise), .fall_o(de_fall)
    );
    hdmi_edge_det #(.RST_VAL(1'b1)) u_vsync_edge (
        .clk(clk), .rst(rst), .sig_i(vsync), .rise_o(frame_start), .fall_o(vsync_fall_unused)
    );

    assign wr_buf    = fetch_line_q[0];
    assign rd_buf    = disp_line_q[0];
    assign rd_req    = rd_req_q;
    assign rd_addr   = rd_addr_q;
    assign rd_len    = RD_LEN_W'(LINE_WORDS);
    assign underflow = underflow_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        done_ok     = (state_q == ST_WAIT) && rd_done && !discard_q && !frame_start;
        disp_adv    = de_fall && (disp_line_q < V_LINES);
        pend_inc    = disp_adv && ((int'(disp_line_q) + 2) < V_ACTIVE_LINE);
        buf_valid_d = buf_valid_q;
        if (disp_adv) buf_valid_d[rd_buf] = 1'b0;
        if (done_ok)  buf_valid_d[wr_buf] = 1'b1;
        // Simultaneous completion and line end net out; never more than two lines ahead.
        pend_sum  = {1'b0, pending_q} + {2'b00, pend_inc} - {2'b00, done_ok};
        pending_d = (pend_sum > 3'd2) ? 2'd2 : pend_sum[1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= BASE_ADDR;
            pending_q    <= 2'd0;
            buf_valid_q  <= 2'b00;
            disp_line_q  <= '0;
            fetch_line_q <= '0;
            discard_q    <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            underflow_q <= de_rise && !buf_valid_q[rd_buf] && (disp_line_q < V_LINES) && !frame_start;

            if (frame_start) begin
                disp_line_q  <= '0;
                fetch_line_q <= '0;
                buf_valid_q  <= 2'b00;
                pending_q    <= PEND_INIT;
            end else begin
                disp_line_q  <= disp_line_q + LINE_W'(disp_adv);
                fetch_line_q <= fetch_line_q + LINE_W'(done_ok);
                buf_valid_q  <= buf_valid_d;
                pending_q    <= pending_d;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        rd_addr_q <= BASE_ADDR;
                    end else if (en && (pending_q != 2'd0) && (fetch_line_q < V_LINES)) begin
                        state_q  <= ST_REQ;
                        rd_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // A new frame mid-request lets the bus see a stable request; the rewind waits for the ack.
                    if (frame_start) discard_q <= 1'b1;
                    if (rd_ack) begin
                        state_q  <= ST_WAIT;
                        rd_req_q <= 1'b0;
                        if (frame_start || discard_q) rd_addr_q <= BASE_ADDR;
                    end
                end
                ST_WAIT: begin
                    if (rd_done) begin
                        state_q   <= ST_IDLE;
                        discard_q <= 1'b0;
                        if (frame_start)     rd_addr_q <= BASE_ADDR;
                        else if (!discard_q) rd_addr_q <= rd_addr_q + LINE_STRIDE;
                    end else if (frame_start) begin
                        discard_q <= 1'b1;
                        rd_addr_q <= BASE_ADDR;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    rd_req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hdmi_line_fetch_ctrl.sv
// Directed bench: a bus responder answers requests, a monitor checks each one against a scoreboard.
module tb_hdmi_line_fetch_ctrl;
    localparam int          V      = 4;
    localparam int          LW     = 8;
    localparam logic [31:0] BASE   = 32'h100;
    localparam logic [31:0] STRIDE = 32'h10;

    logic clk = 1'b0, rst = 1'b1, en = 1'b1, de = 1'b0, vsync = 1'b1;
    logic rd_ack = 1'b0, rd_done = 1'b0;
    logic rd_req, wr_buf, rd_buf, underflow;
    logic [31:0] rd_addr;
    logic [15:0] rd_len;

    always #5 clk = ~clk;

    hdmi_line_fetch_ctrl #(
        .V_ACTIVE_LINE(V), .LINE_WORDS(LW), .ADDR_WIDTH(32),
        .BASE_ADDR(BASE), .LINE_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .de(de), .vsync(vsync),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_ack(rd_ack), .rd_done(rd_done),
        .wr_buf(wr_buf), .rd_buf(rd_buf), .underflow(underflow)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    int   chk = 0, err = 0;
    int   req_seen = 0, uf_count = 0;
    int   hold_at = -1, done_req = 0, done_served = 0, resp_idx = 0;
    int   resp_phase = 0, resp_cnt = 0;
    logic prev_req = 1'b0, uf_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic exp_req(input logic [31:0] a, input logic w);
        exp_t e;
        e.addr = a;
        e.wr   = w;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start_pulse();
        vsync = 1'b0;
        tick(2);
        vsync = 1'b1;
        tick(1);
    endtask

    task automatic line(input logic exp_buf);
        de = 1'b1;
        tick(1);
        check("rd_buf", 32'(rd_buf), 32'(exp_buf));
        check("no_underflow", 32'(underflow), 0);
        tick(7);
        de = 1'b0;
        tick(8);
    endtask

    // Monitor: every new request is popped from the scoreboard and compared.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_req && !prev_req) begin
                req_seen++;
                check("req_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rd_addr", rd_addr, e.addr);
                    check("wr_buf", 32'(wr_buf), 32'(e.wr));
                    check("rd_len", 32'(rd_len), LW);
                end
            end
            if (underflow) begin
                uf_count++;
                check("underflow_width", 32'(uf_prev), 0);
            end
            prev_req = rd_req;
            uf_prev  = underflow;
        end
    end

    // Responder: ack on sight, done four cycles later, or on demand for the held request.
    initial begin
        forever begin
            @(negedge clk);
            rd_ack  = 1'b0;
            rd_done = 1'b0;
            if (rst) begin
                resp_phase = 0;
            end else begin
                case (resp_phase)
                    0: if (rd_req) begin
                        rd_ack     = 1'b1;
                        resp_phase = (resp_idx == hold_at) ? 3 : 2;
                        resp_cnt   = 0;
                        resp_idx++;
                    end
                    2: begin
                        resp_cnt++;
                        if (resp_cnt == 4) begin
                            rd_done    = 1'b1;
                            resp_phase = 0;
                        end
                    end
                    3: if (done_req != done_served) begin
                        done_served++;
                        rd_done    = 1'b1;
                        resp_phase = 0;
                    end
                    default: resp_phase = 0;
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  base, uf0;
        logic seen;

        tick(2);
        check("rst_rd_req", 32'(rd_req), 0);
        check("rst_rd_addr", rd_addr, BASE);
        check("rst_rd_len", 32'(rd_len), LW);
        check("rst_wr_buf", 32'(wr_buf), 0);
        check("rst_rd_buf", 32'(rd_buf), 0);
        check("rst_underflow", 32'(underflow), 0);
        rst = 1'b0;
        tick(2);

        // Enable gating, then a full four-line frame with prompt completions.
        en = 1'b0;
        frame_start_pulse();
        tick(10);
        check("en_blocks_req", req_seen, 0);
        exp_req(32'h100, 1'b0);
        exp_req(32'h110, 1'b1);
        en = 1'b1;
        tick(30);
        check("prefetch_two", req_seen, 2);
        exp_req(32'h120, 1'b0);
        exp_req(32'h130, 1'b1);
        line(1'b0); line(1'b1); line(1'b0); line(1'b1);
        tick(20);
        check("frame_req_count", req_seen, 4);
        check("sb_drained_frame", sb.size(), 0);
        check("no_underflow_frame", uf_count, 0);

        // Line 1 data withheld past its de rise.
        base = req_seen; uf0 = uf_count; hold_at = base + 1;
        exp_req(32'h100, 1'b0);
        exp_req(32'h110, 1'b1);
        frame_start_pulse();
        tick(30);
        check("held_second_req", req_seen, base + 2);
        line(1'b0);
        de = 1'b1;
        tick(1);
        check("underflow_pulse", 32'(underflow), 1);
        check("rd_buf_line1", 32'(rd_buf), 1);
        tick(1);
        check("underflow_cleared", 32'(underflow), 0);
        exp_req(32'h120, 1'b0);
        exp_req(32'h130, 1'b1);
        done_req++;
        tick(6);
        de = 1'b0;
        tick(8);
        hold_at = -1;
        line(1'b0); line(1'b1);
        tick(20);
        check("sb_drained_uf", sb.size(), 0);
        check("underflow_once", uf_count - uf0, 1);
        check("uf_frame_req_count", req_seen, base + 4);

        // Completion of line 1 lands in the same cycle as line 0's de fall.
        base = req_seen; uf0 = uf_count; hold_at = base + 1;
        exp_req(32'h100, 1'b0);
        exp_req(32'h110, 1'b1);
        frame_start_pulse();
        tick(30);
        check("held_second_req2", req_seen, base + 2);
        de = 1'b1;
        tick(1);
        check("rd_buf_line0", 32'(rd_buf), 0);
        tick(6);
        exp_req(32'h120, 1'b0);
        @(posedge clk);
        #1 done_req++;
        @(negedge clk);
        de = 1'b0;
        tick(8);
        hold_at = -1;
        de = 1'b1;
        tick(1);
        check("same_cycle_buf1_valid", 32'(underflow), 0);
        tick(7);
        check("pending_net_zero", req_seen, base + 3);
        exp_req(32'h130, 1'b1);
        de = 1'b0;
        tick(8);
        line(1'b0); line(1'b1);
        tick(20);
        check("sb_drained_same", sb.size(), 0);
        check("no_underflow_same", uf_count - uf0, 0);
        check("same_req_count", req_seen, base + 4);

        // New frame while waiting on line 2: that completion is dropped.
        base = req_seen; hold_at = base + 2;
        exp_req(32'h100, 1'b0);
        exp_req(32'h110, 1'b1);
        exp_req(32'h120, 1'b0);
        frame_start_pulse();
        tick(30);
        line(1'b0);
        check("waiting_0x120", req_seen, base + 3);
        exp_req(32'h100, 1'b0);
        exp_req(32'h110, 1'b1);
        frame_start_pulse();
        tick(3);
        done_req++;
        tick(30);
        hold_at = -1;
        check("sb_drained_discard", sb.size(), 0);
        check("discard_req_count", req_seen, base + 5);

        // Reset during an asserted request.
        base = req_seen;
        exp_req(32'h100, 1'b0);
        frame_start_pulse();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rd_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_before_rst", 32'(seen), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_drops_req", 32'(rd_req), 0);
        check("rst_reload_addr", rd_addr, BASE);
        tick(2);
        rst = 1'b0;
        tick(20);
        check("no_req_after_rst", req_seen, base + 1);
        exp_req(32'h100, 1'b0);
        exp_req(32'h110, 1'b1);
        frame_start_pulse();
        tick(30);
        check("sb_drained_rst", sb.size(), 0);
        check("rst_resume_count", req_seen, base + 3);

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule

// File: doc/hdmi_line_fetch_ctrl.md
HDMI_LINE_FETCH_CTRL -- requirements
Module: hdmi_line_fetch_ctrl

Interface
REQ-001 SHALL have parameter V_ACTIVE_LINE, default 720: active lines per frame.
REQ-002 SHALL have parameter LINE_WORDS, default 160: memory words per active line, issued as rd_len.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: width of rd_addr.
REQ-004 SHALL have parameter BASE_ADDR, default 0: address of line 0.
REQ-005 SHALL have parameter LINE_STRIDE, default 640: address increment per line.
REQ-006 SHALL have ports: clk  in  1  sole clock; rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports: en  in  1  fetch enable; de  in  1  timing data-enable; vsync  in  1  timing vsync, active low.
REQ-008 SHALL have ports: rd_req  out  1; rd_addr  out  ADDR_WIDTH; rd_len  out  16; rd_ack  in  1  request accepted; rd_done  in  1  one-cycle pulse, line data written.
REQ-009 SHALL have ports: wr_buf  out  1  ping-pong half being filled; rd_buf  out  1  half the display reads; underflow  out  1  one-cycle error pulse.

Function
REQ-010 SHALL register de and vsync once; de_fall = de_d & !de; de_rise = !de_d & de; frame_start = !vsync_d & vsync.
REQ-011 SHALL implement states IDLE, REQ, WAIT.
REQ-012 IDLE->REQ when en=1 and pending>0; REQ->WAIT on rd_ack; WAIT->IDLE on rd_done.
REQ-013 SHALL hold rd_req=1 only in REQ; rd_addr and rd_len SHALL stay stable until rd_ack.
REQ-014 Each request SHALL have exactly one outstanding transfer; new requests SHALL NOT issue in WAIT.
REQ-015 rd_len SHALL equal LINE_WORDS constantly.
REQ-016 rd_addr SHALL equal BASE_ADDR + fetch_line*LINE_STRIDE, produced by an accumulator (no multiplier); it SHALL wrap modulo 2^ADDR_WIDTH.
REQ-017 On frame_start: disp_line=0, fetch_line=0, buf_valid=00, pending=min(2,V_ACTIVE_LINE).
REQ-018 wr_buf SHALL equal fetch_line[0]; rd_buf SHALL equal disp_line[0].
REQ-019 On rd_done (non-discarded): set buf_valid[wr_buf], increment fetch_line, decrement pending.
REQ-020 On de_fall: clear buf_valid[rd_buf], increment disp_line; if disp_line+2 < V_ACTIVE_LINE, increment pending.
REQ-021 pending SHALL saturate at 2 and never exceed two lines ahead of disp_line.
REQ-022 On de_rise with buf_valid[rd_buf]=0, underflow SHALL pulse one cycle; display of that line proceeds.
REQ-023 rd_done and de_fall in the same cycle SHALL both apply; pending change is the net of +1 and -1.
REQ-024 frame_start in WAIT SHALL set discard; the following rd_done SHALL be ignored for buf_valid, fetch_line and pending; discard then clears.
REQ-025 frame_start in REQ SHALL leave the request asserted; rd_addr SHALL reload to BASE_ADDR only after rd_ack.
REQ-026 en=0 SHALL block IDLE->REQ only; an in-flight request SHALL complete normally.
REQ-027 After V_ACTIVE_LINE lines, no request SHALL issue until the next frame_start.

Reset
REQ-028 On rst=1, all outputs and state SHALL take reset values asynchronously: state IDLE, rd_req=0, rd_addr=BASE_ADDR, pending=0, buf_valid=00, disp_line=0, fetch_line=0, discard=0, underflow=0, de_d=0, vsync_d=1.
REQ-029 Reset asserted mid-transfer SHALL drop rd_req immediately; the block SHALL resume only at the next frame_start.

Structure
REQ-030 The state encoding and rd_len width constant (16) SHALL reside in the shared package hdmi_pkg.
REQ-031 The de/vsync edge detection SHALL be one sub-module, hdmi_edge_det, instantiated twice.
REQ-032 Line counters SHALL be sized $clog2(V_ACTIVE_LINE+1).

Verification (V_ACTIVE_LINE=4, LINE_WORDS=8, BASE_ADDR=0x100, LINE_STRIDE=0x10)
REQ-033 frame_start, rd_ack after 1 cycle, rd_done after 5 cycles -> requests at addresses 0x100 then 0x110, wr_buf 0 then 1, no underflow.
REQ-034 Four de pulses with prompt rd_done -> exactly 4 requests (0x100, 0x110, 0x120, 0x130), rd_buf 0,1,0,1, none after line 3.
REQ-035 rd_done withheld past line 1 de_rise -> underflow pulses exactly once, one cycle wide.
REQ-036 rd_done and de_fall in the same cycle -> pending unchanged, buf_valid updated for both halves.
REQ-037 frame_start during WAIT for 0x120 -> that rd_done discarded, next request at 0x100.
REQ-038 rst pulse while rd_req=1 -> rd_req=0 in the same cycle, no request until frame_start.
